// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the drawing-engine arbiter.
package draw_arb_pkg;

  // Arbiter phases: pick a job, pulse start, wait for done/timeout, acknowledge.
  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RELEASE
  } arb_state_t;

  // VGA adapter pixel field widths (160x120, 3-bit colour).
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  // Slot index width covers the largest supported engine count (8).
  localparam int MAX_ENG = 8;
  localparam int ID_W    = 3;

  // Watchdog counter width; it never needs to hold TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request bit
// searching upward from last_grant+1, wrapping around.
module rr_picker
  import draw_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_grant,
  output logic            valid,
  output logic [ID_W-1:0] index
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] cand;

  // Scan the N candidates in rotated order and keep the first requester.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_grant) + k) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Shares the VGA adapter write port among N_ENG drawing engines. Jobs are
// granted one at a time in round-robin order; a watchdog aborts engines
// that never raise done.
module draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int N_ENG   = 4,
  parameter int TIMEOUT = 32768
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_ENG-1:0]     req,
  output logic [N_ENG-1:0]     ack,
  output logic [N_ENG-1:0]     eng_start,
  input  logic [N_ENG-1:0]     eng_done,
  input  logic [X_W*N_ENG-1:0] eng_x,
  input  logic [Y_W*N_ENG-1:0] eng_y,
  input  logic [C_W*N_ENG-1:0] eng_colour,
  input  logic [N_ENG-1:0]     eng_plot,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [C_W-1:0]       vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_err
);

  localparam int              CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t          state;
  logic [ID_W-1:0]     last_grant;
  logic [CNT_W-1:0]    wd_cnt;
  logic                pick_valid;
  logic [ID_W-1:0]     pick_idx;
  logic                running;
  logic [MAX_ENG-1:0]  done_pad;
  logic [MAX_ENG-1:0]  plot_pad;
  logic [MAX_ENG-1:0]  g_onehot;
  logic [MAX_ENG-1:0]  pick_onehot;
  logic [X_W-1:0]      x_slot [MAX_ENG];
  logic [Y_W-1:0]      y_slot [MAX_ENG];
  logic [C_W-1:0]      c_slot [MAX_ENG];
  logic [X_W-1:0]      hold_x;
  logic [Y_W-1:0]      hold_y;
  logic [C_W-1:0]      hold_c;

  // Unpack engine buses into per-slot fields; unused slots read as zero so
  // a 3-bit grant index always addresses a defined entry.
  for (genvar i = 0; i < MAX_ENG; i++) begin : g_slot
    if (i < N_ENG) begin : g_used
      assign x_slot[i] = eng_x[X_W*i +: X_W];
      assign y_slot[i] = eng_y[Y_W*i +: Y_W];
      assign c_slot[i] = eng_colour[C_W*i +: C_W];
    end else begin : g_unused
      assign x_slot[i] = '0;
      assign y_slot[i] = '0;
      assign c_slot[i] = '0;
    end
  end

  assign done_pad    = MAX_ENG'(eng_done);
  assign plot_pad    = MAX_ENG'(eng_plot);
  assign g_onehot    = MAX_ENG'(1) << grant_id;
  assign pick_onehot = MAX_ENG'(1) << pick_idx;
  assign running     = (state == START) || (state == WAIT);

  rr_picker #(.N(N_ENG)) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  // Job sequencer: grant, start, watchdog, acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      last_grant  <= ID_W'(N_ENG - 1);
      wd_cnt      <= '0;
      eng_start   <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id  <= pick_idx;
            eng_start <= pick_onehot[N_ENG-1:0];
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          // done takes priority over a coincident timeout
          if (done_pad[grant_id] || (wd_cnt == CNT_LAST)) begin
            eng_start <= '0;
            ack       <= g_onehot[N_ENG-1:0];
            state     <= RELEASE;
            if (!done_pad[grant_id]) timeout_err <= 1'b1;
          end
        end
        RELEASE: begin
          ack        <= '0;
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Remember the last pixel fields of the running job so x/y/colour stay
  // steady between jobs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these few output registers are reset so the adapter sees zeros while reset is held.
    if (!rst_n) begin
      hold_x <= '0;
      hold_y <= '0;
      hold_c <= '0;
    end else if (running) begin
      hold_x <= x_slot[grant_id];
      hold_y <= y_slot[grant_id];
      hold_c <= c_slot[grant_id];
    end
  end

  // Pixel mux: live pass-through of the granted engine while it runs, plot
  // suppressed at all other times.
  always_comb begin
    vga_x      = hold_x;
    vga_y      = hold_y;
    vga_colour = hold_c;
    vga_plot   = 1'b0;
    if (running) begin
      vga_x      = x_slot[grant_id];
      vga_y      = y_slot[grant_id];
      vga_colour = c_slot[grant_id];
      vga_plot   = plot_pad[grant_id];
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: engine/requester models plus a
// job-timeline reference model, directed scenarios then random traffic.
module tb_draw_arbiter;

  localparam int N  = 4;
  localparam int TO = 32;

  typedef logic [1:0] slot_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   ack;
  logic [N-1:0]   eng_start;
  logic [N-1:0]   eng_done;
  logic [8*N-1:0] eng_x;
  logic [7*N-1:0] eng_y;
  logic [3*N-1:0] eng_colour;
  logic [N-1:0]   eng_plot;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           busy;
  logic [2:0]     grant_id;
  logic           timeout_err;

  always #5 clk = ~clk;

  draw_arbiter #(.N_ENG(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_colour  (eng_colour),
    .eng_plot    (eng_plot),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  // Per-slot engine outputs, packed onto the DUT buses.
  logic [7:0] ex [N];
  logic [6:0] ey [N];
  logic [2:0] ec [N];
  logic       dn [N];
  logic       pl [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign eng_x[8*i +: 8]      = ex[i];
    assign eng_y[7*i +: 7]      = ey[i];
    assign eng_colour[3*i +: 3] = ec[i];
    assign eng_done[i]          = dn[i];
    assign eng_plot[i]          = pl[i];
  end

  // Engine / requester behaviour knobs and observation counters.
  int lat [N];
  int run [N];
  int start_cnt [N];
  int ack_cnt [N];
  bit hang [N];
  bit one_shot [N];
  bit noise;
  int grants [$];
  logic [N-1:0] prev_start;

  // Reference model: one job at a time, described by its timeline.
  bit    m_active;
  slot_t m_slot;
  slot_t m_last;
  int    m_age;
  int    m_on;
  bit    m_abort;
  bit    m_terr;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic slot_t rr_pick(input logic [N-1:0] r, input slot_t last);
    slot_t c;
    for (int k = 1; k <= N; k++) begin
      c = slot_t'((int'(last) + k) % N);
      if (r[c]) return c;
    end
    return last;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_slot   = '0;
    m_last   = slot_t'(N - 1);
    m_age    = 0;
    m_on     = 0;
    m_abort  = 1'b0;
    m_terr   = 1'b0;
  endtask

  task automatic clear_stats();
    grants.delete();
    for (int i = 0; i < N; i++) begin
      start_cnt[i] = 0;
      ack_cnt[i]   = 0;
    end
  endtask

  // One clock cycle: advance the model, let engines/requesters react, compare.
  task automatic tick();
    logic [N-1:0] exp_start;
    logic [N-1:0] exp_ack;
    bit           live;
    if (m_active) begin
      m_age++;
      if (m_age > m_on) begin
        m_active = 1'b0;
        m_last   = m_slot;
      end else if (m_age == m_on && m_abort) begin
        m_terr = 1'b1;
      end
    end else if (req != '0) begin
      m_slot   = rr_pick(req, m_last);
      m_active = 1'b1;
      m_age    = 0;
      m_abort  = hang[m_slot] || (lat[m_slot] > TO);
      m_on     = m_abort ? TO + 1 : lat[m_slot] + 1;
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      slot_t s;
      s = slot_t'(i);
      if (eng_start[s]) run[i]++;
      else run[i] = 0;
      dn[i] = eng_start[s] && !hang[i] && (run[i] > lat[i]);
      ex[i] = 8'($urandom);
      ey[i] = 7'($urandom);
      ec[i] = 3'($urandom);
      pl[i] = 1'($urandom);
      if (eng_start[s]) start_cnt[i]++;
      if (ack[s]) begin
        ack_cnt[i]++;
        if (one_shot[i]) req[s] = 1'b0;
      end
    end
    if (noise) begin
      dn[2] = 1'b1;
      pl[2] = 1'b1;
      ex[2] = 8'hFF;
    end
    if (eng_start != '0 && prev_start == '0) grants.push_back(int'(grant_id));
    prev_start = eng_start;
    #1;

    live      = m_active && (m_age < m_on);
    exp_start = live ? (N'(1) << m_slot) : '0;
    exp_ack   = (m_active && m_age == m_on) ? (N'(1) << m_slot) : '0;
    check("busy", 32'(busy), 32'(m_active));
    check("grant_id", 32'(grant_id), 32'(m_slot));
    check("eng_start", 32'(eng_start), 32'(exp_start));
    check("ack", 32'(ack), 32'(exp_ack));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
    check("vga_plot", 32'(vga_plot), live ? 32'(pl[m_slot]) : 32'd0);
    if (live) begin
      check("vga_x", 32'(vga_x), 32'(ex[m_slot]));
      check("vga_y", 32'(vga_y), 32'(ey[m_slot]));
      check("vga_colour", 32'(vga_colour), 32'(ec[m_slot]));
    end
  endtask

  // Assert reset between clock edges and check it takes hold with no edge.
  task automatic async_reset_check();
    for (int i = 0; i < N; i++) begin
      ex[i] = 8'($urandom) | 8'h01;
      ey[i] = 7'($urandom) | 7'h01;
      ec[i] = 3'($urandom) | 3'h1;
      pl[i] = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_vga_plot", 32'(vga_plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_vga_x", 32'(vga_x), 32'd0);
    check("rst_vga_y", 32'(vga_y), 32'd0);
    check("rst_vga_colour", 32'(vga_colour), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    model_reset();
    for (int i = 0; i < N; i++) begin
      run[i] = 0;
      dn[i]  = 1'b0;
    end
    prev_start = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_req();
    for (int i = 0; i < N; i++) begin
      slot_t s;
      s = slot_t'(i);
      if (!req[s] && $urandom_range(3) == 0) begin
        lat[i]  = $urandom_range(40, 1);
        hang[i] = ($urandom_range(7) == 0);
        req[s]  = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    req        = '0;
    noise      = 1'b0;
    prev_start = '0;
    for (int i = 0; i < N; i++) begin
      lat[i] = 4; hang[i] = 1'b0; one_shot[i] = 1'b1; run[i] = 0;
      dn[i] = 1'b0; pl[i] = 1'b0; ex[i] = '0; ey[i] = '0; ec[i] = '0;
    end
    model_reset();
    clear_stats();
    #2;
    async_reset_check();

    // Single job on slot 1, engine done after 10 cycles.
    clear_stats();
    lat[1] = 10;
    req    = 4'b0010;
    repeat (20) tick();
    check("single_start_cycles", 32'(start_cnt[1]), 32'd11);
    check("single_ack_count", 32'(ack_cnt[1]), 32'd1);

    // Simultaneous requests from reset: order 0,1,3.
    async_reset_check();
    clear_stats();
    lat[0] = 4; lat[1] = 6; lat[3] = 3;
    req = 4'b1011;
    repeat (40) tick();
    check("sim_grant_count", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      check("sim_grant0", 32'(grants[0]), 32'd0);
      check("sim_grant1", 32'(grants[1]), 32'd1);
      check("sim_grant2", 32'(grants[2]), 32'd3);
    end
    check("sim_ack0", 32'(ack_cnt[0]), 32'd1);
    check("sim_ack1", 32'(ack_cnt[1]), 32'd1);
    check("sim_ack2", 32'(ack_cnt[2]), 32'd0);
    check("sim_ack3", 32'(ack_cnt[3]), 32'd1);

    // All requests held: strict rotation.
    clear_stats();
    for (int i = 0; i < N; i++) begin
      one_shot[i] = 1'b0;
      lat[i]      = $urandom_range(5, 2);
    end
    req = 4'b1111;
    n = 0;
    while (grants.size() < 8 && n < 300) begin
      tick();
      n++;
    end
    check("rot_grants_within_budget", 32'(grants.size() >= 8), 32'd1);
    req = '0;
    repeat (12) tick();
    for (int i = 0; i < N; i++) one_shot[i] = 1'b1;
    if (grants.size() >= 8) begin
      for (int j = 0; j < 8; j++) check("rot_grant_seq", 32'(grants[j]), 32'(j % N));
    end

    // Watchdog: engine 2 hangs, then a normal job on slot 2.
    clear_stats();
    hang[2] = 1'b1;
    req     = 4'b0100;
    repeat (40) tick();
    check("wd_start_cycles", 32'(start_cnt[2]), 32'(TO + 1));
    check("wd_ack_count", 32'(ack_cnt[2]), 32'd1);
    check("wd_err_set", 32'(timeout_err), 32'd1);
    hang[2] = 1'b0;
    lat[2]  = 5;
    req     = 4'b0100;
    repeat (12) tick();
    check("wd_next_ack_count", 32'(ack_cnt[2]), 32'd2);
    check("wd_err_sticky", 32'(timeout_err), 32'd1);

    // Noise on a non-granted slot while slot 0 runs.
    clear_stats();
    lat[0] = 12;
    noise  = 1'b1;
    req    = 4'b0001;
    repeat (20) tick();
    noise = 1'b0;
    check("noise_start_cycles", 32'(start_cnt[0]), 32'd13);
    check("noise_ack_count", 32'(ack_cnt[0]), 32'd1);
    check("noise_no_other_ack", 32'(ack_cnt[2]), 32'd0);

    // Reset in the middle of slot 0's run; slot 0 must win again afterwards.
    clear_stats();
    lat[0] = 30;
    req    = 4'b0001;
    repeat (6) tick();
    check("midrst_running", 32'(eng_start), 32'd1);
    async_reset_check();
    clear_stats();
    lat[2] = 5;
    req    = 4'b0101;
    repeat (45) tick();
    check("midrst_have_grant", 32'(grants.size() >= 1), 32'd1);
    if (grants.size() >= 1) check("midrst_first_grant", 32'(grants[0]), 32'd0);
    check("midrst_ack0", 32'(ack_cnt[0]), 32'd1);

    // Random traffic against the model.
    clear_stats();
    for (int t = 0; t < 600; t++) begin
      rand_req();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
